// File: rtl/uart_alu_pkg.sv
// rtl/uart_alu_pkg.sv - opcode and FSM state encodings shared by the uart_alu command path
package uart_alu_pkg;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_NOR = 6'h27;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_SRL = 6'h02;

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_TX = 3'd4
  } state_e;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU; unknown opcodes give zero and raise invalid_o
module alu_core
  import uart_alu_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic [NB_DATA-1:0] a_i,
  input  logic [NB_DATA-1:0] b_i,
  input  logic [NB_OP-1:0]   op_i,
  output logic [NB_DATA-1:0] result_o,
  output logic               invalid_o
);

  logic [5:0] op6;
  assign op6 = 6'(op_i);

  always_comb begin
    result_o  = '0;
    invalid_o = 1'b0;
    case (op6)
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_NOR:  result_o = ~(a_i | b_i);
      // Shift distance uses only the low three bits of B.
      OP_SRA:  result_o = $signed(a_i) >>> b_i[2:0];
      OP_SRL:  result_o = a_i >> b_i[2:0];
      default: invalid_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/uart_alu_cmd.sv
// rtl/uart_alu_cmd.sv - collects A, B, opcode bytes from uart_rx and sends the ALU result to uart_tx
// Optional inter-byte timeout is built when UART_ALU_TIMEOUT_EN is defined.
module uart_alu_cmd
  import uart_alu_pkg::*;
#(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_err_op,
  output logic               o_err_ovr,
  output logic               o_busy
);

  state_e             state_q;
  logic [NB_DATA-1:0] a_q, b_q, result_q;
  logic               tx_start_q, err_op_q, err_ovr_q, busy_q;
  logic [NB_DATA-1:0] alu_result_d;
  logic               alu_invalid_d;

`ifdef UART_ALU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q;
`endif

  alu_core #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .op_i     (i_rx_data[NB_OP-1:0]),
    .result_o (alu_result_d),
    .invalid_o(alu_invalid_d)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_WAIT_A;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      tx_start_q <= 1'b0;
      err_op_q   <= 1'b0;
      err_ovr_q  <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_ALU_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        ST_WAIT_A: if (i_rx_done) begin
          a_q     <= i_rx_data;
          state_q <= ST_WAIT_B;
        end
        ST_WAIT_B: if (i_rx_done) begin
          b_q     <= i_rx_data;
          state_q <= ST_WAIT_OP;
        end
        ST_WAIT_OP: if (i_rx_done) begin
          result_q   <= alu_result_d;
          err_op_q   <= err_op_q | alu_invalid_d;
          tx_start_q <= 1'b1;
          busy_q     <= 1'b1;
          state_q    <= ST_SEND;
        end
        ST_SEND: begin
          if (i_rx_done) err_ovr_q <= 1'b1;
          state_q <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          if (i_rx_done) err_ovr_q <= 1'b1;
          if (i_tx_done) begin
            busy_q  <= 1'b0;
            state_q <= ST_WAIT_A;
          end
        end
        default: state_q <= ST_WAIT_A;
      endcase
`ifdef UART_ALU_TIMEOUT_EN
      // An accepted byte wins over an expiring count in the same cycle.
      if ((state_q == ST_WAIT_B || state_q == ST_WAIT_OP) && !i_rx_done) begin
        if (cnt_q == TO_LAST) begin
          cnt_q   <= '0;
          state_q <= ST_WAIT_A;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
`endif
    end
  end

  assign o_tx_data  = result_q;
  assign o_tx_start = tx_start_q;
  assign o_err_op   = err_op_q;
  assign o_err_ovr  = err_ovr_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_uart_alu_cmd.sv
// tb/tb_uart_alu_cmd.sv - scoreboard bench for uart_alu_cmd
module tb_uart_alu_cmd;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b0;
  logic [7:0] i_rx_data = '0;
  logic       i_rx_done = 1'b0;
  logic       i_tx_done = 1'b0;
  logic [7:0] o_tx_data;
  logic       o_tx_start, o_err_op, o_err_ovr, o_busy;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic       prev_start = 1'b0;

  uart_alu_cmd #(.NB_DATA(8), .NB_OP(6), .TIMEOUT_CYCLES(100)) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_rx_data (i_rx_data),
    .i_rx_done (i_rx_done),
    .i_tx_done (i_tx_done),
    .o_tx_data (o_tx_data),
    .o_tx_start(o_tx_start),
    .o_err_op  (o_err_op),
    .o_err_ovr (o_err_ovr),
    .o_busy    (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every start pulse must match the oldest expected byte.
  always @(negedge i_clk) begin
    if (o_tx_start) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tx: got %0h expected none", o_tx_data);
      end else begin
        check("tx_data", {24'h0, o_tx_data}, {24'h0, exp_q.pop_front()});
      end
      if (prev_start) check("start_one_cycle", 32'(prev_start), 32'd0);
    end
    prev_start = o_tx_start;
  end

  task automatic rx(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(negedge i_clk);
    i_rx_done = 1'b0;
  endtask

  task automatic cmd(input string nm, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] op, input logic [7:0] exp);
    rx(a);
    rx(b);
    exp_q.push_back(exp);
    rx(op);
    check({nm, "_start_latency"}, 32'(o_tx_start), 32'd1);
    check({nm, "_busy"}, 32'(o_busy), 32'd1);
    repeat (3) @(negedge i_clk);
  endtask

  task automatic tx_done(input string nm, input logic with_rx);
    i_tx_done = 1'b1;
    if (with_rx) begin
      i_rx_data = 8'hAA;
      i_rx_done = 1'b1;
    end
    @(negedge i_clk);
    i_tx_done = 1'b0;
    i_rx_done = 1'b0;
    check({nm, "_idle"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    check("reset_outputs", {19'h0, o_tx_start, o_err_op, o_err_ovr, o_busy, o_tx_data}, 32'h0);

    cmd("add", 8'h05, 8'h03, 8'h20, 8'h08);
    tx_done("add", 1'b0);
    cmd("sub", 8'h03, 8'h05, 8'h22, 8'hFE);
    tx_done("sub", 1'b0);
    cmd("sra", 8'h80, 8'h02, 8'h03, 8'hE0);
    tx_done("sra", 1'b0);
    cmd("srl", 8'h80, 8'h0A, 8'h02, 8'h20);
    tx_done("srl", 1'b0);
    cmd("and", 8'hF0, 8'h3C, 8'h24, 8'h30);
    tx_done("and", 1'b0);
    cmd("xor", 8'hFF, 8'h0F, 8'h26, 8'hF0);
    tx_done("xor", 1'b0);
    cmd("nor", 8'h01, 8'h02, 8'h27, 8'hFC);
    tx_done("nor", 1'b0);
    // Upper opcode bits ignored, carry dropped.
    cmd("add_wrap", 8'hFF, 8'h01, 8'hE0, 8'h00);
    tx_done("add_wrap", 1'b0);
    check("err_op_clear", 32'(o_err_op), 32'd0);

    // tx_done outside WAIT_TX must not disturb the command.
    rx(8'h40);
    i_tx_done = 1'b1;
    @(negedge i_clk);
    i_tx_done = 1'b0;
    rx(8'h02);
    exp_q.push_back(8'h10);
    rx(8'h02);
    check("stray_txdone_start", 32'(o_tx_start), 32'd1);
    repeat (2) @(negedge i_clk);
    tx_done("stray_txdone", 1'b0);

    cmd("invalid", 8'h11, 8'h22, 8'h3F, 8'h00);
    tx_done("invalid", 1'b0);
    check("err_op_set", 32'(o_err_op), 32'd1);
    cmd("or", 8'h0F, 8'h30, 8'h25, 8'h3F);
    tx_done("or", 1'b0);
    check("err_op_sticky", 32'(o_err_op), 32'd1);
    check("err_ovr_clear", 32'(o_err_ovr), 32'd0);

    cmd("ovr_cmd", 8'h10, 8'h20, 8'h20, 8'h30);
    rx(8'h55);
    check("ovr_still_busy", 32'(o_busy), 32'd1);
    tx_done("ovr_coincident", 1'b1);
    check("err_ovr_set", 32'(o_err_ovr), 32'd1);
    cmd("after_ovr", 8'h01, 8'h01, 8'h20, 8'h02);
    tx_done("after_ovr", 1'b0);

    rx(8'h33);
    rx(8'h44);
    i_reset = 1'b0;
    @(negedge i_clk);
    check("midreset_outputs", {19'h0, o_tx_start, o_err_op, o_err_ovr, o_busy, o_tx_data}, 32'h0);
    i_reset = 1'b1;
    @(negedge i_clk);
    cmd("after_reset", 8'h0F, 8'hF0, 8'h25, 8'hFF);
    tx_done("after_reset", 1'b0);

`ifdef UART_ALU_TIMEOUT_EN
    rx(8'h07);
    repeat (100) @(negedge i_clk);
    cmd("timeout", 8'h01, 8'h02, 8'h20, 8'h03);
    tx_done("timeout", 1'b0);
`endif

    repeat (3) @(negedge i_clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
